// File: rtl/decade_pkg.sv
// decade_pkg: shared BCD type, terminal value and increment-with-wrap helper
package decade_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  function automatic bcd_t bcd_inc(input bcd_t v);
    return (v >= BCD_MAX) ? '0 : v + 4'd1;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit (clk, rst sync high, en advance, q value, tc = en & q==9); codes 10-15 advance to 0
module bcd_digit
  import decade_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output bcd_t q,
  output logic tc
);
  bcd_t r_q;
  always_ff @(posedge clk)
    r_q <= rst ? '0 : en ? bcd_inc(r_q) : r_q;
  assign q  = r_q;
  assign tc = en & (r_q == BCD_MAX);
endmodule

// File: rtl/decade_counter.sv
// decade_counter: DIGITS-digit BCD counter (clk, rst sync high, in enable, cnt registered BCD, carry = in & all digits 9)
module decade_counter
  import decade_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  carry
);
  logic [DIGITS-1:0] w_en;
  logic [DIGITS-1:0] w_tc;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    if (g == 0) begin : g_first
      assign w_en[g] = in;
    end else begin : g_next
      assign w_en[g] = w_tc[g-1];
    end
    bcd_digit u_dig (
      .clk (clk),
      .rst (rst),
      .en  (w_en[g]),
      .q   (cnt[4*g+:4]),
      .tc  (w_tc[g])
    );
  end
  assign carry = w_tc[DIGITS-1];
endmodule

// File: tb/tb_decade_counter.sv
// tb_decade_counter: scoreboard bench for one- and two-digit decade counters
module tb_decade_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in  = 1'b0;
  logic [3:0] cnt1;
  logic [7:0] cnt2;
  logic c1, c2;
  int n_tests = 0;
  int n_fail  = 0;
  int n_c1    = 0;
  int m1 = 0;
  int v2 = 0;
  logic [11:0] sb_q[$];

  always #5 clk = ~clk;

  decade_counter #(.DIGITS(1)) u_d1 (.clk(clk), .rst(rst), .in(in), .cnt(cnt1), .carry(c1));
  decade_counter #(.DIGITS(2)) u_d2 (.clk(clk), .rst(rst), .in(in), .cnt(cnt2), .carry(c2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic i);
    logic [11:0] e;
    rst = r;
    in  = i;
    #1;
    chk("carry1", 32'(c1), 32'(i && m1 == 9));
    chk("carry2", 32'(c2), 32'(i && v2 == 99));
    if (c1 === 1'b1) n_c1++;
    m1 = r ? 0 : i ? ((m1 >= 9) ? 0 : m1 + 1) : m1;
    v2 = r ? 0 : i ? (v2 + 1) % 100 : v2;
    sb_q.push_back({4'(v2 / 10), 4'(v2 % 10), 4'(m1)});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("cnt1", 32'(cnt1), 32'(e[3:0]));
      chk("cnt2", 32'(cnt2), 32'(e[11:4]));
    end
  endtask

  initial begin
    rst = 1'b1;
    in  = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_cnt2", 32'(cnt2), 32'd0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    n_c1 = 0;
    for (int k = 0; k < 25; k++) begin
      step(1'b0, 1'b1);
      if (k == 19) chk("carry_in_20", 32'(n_c1), 32'd2);
    end
    for (int k = 0; k < 24; k++) step(1'b0, k[0] ? 1'b0 : 1'b1);
    for (int k = 0; k < 10 && m1 != 7; k++) step(1'b0, 1'b1);
    chk("at_seven", 32'(cnt1), 32'd7);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int k = 0; k < 102; k++) step(1'b0, 1'b1);
    force u_d1.g_dig[0].u_dig.r_q = 4'hC;
    #1;
    release u_d1.g_dig[0].u_dig.r_q;
    m1 = 12;
    chk("forced", 32'(cnt1), 32'hC);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
